// File: rtl/add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-add cell made of two half-adder stages and a carry OR.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-add cell sequenced LSB first over WIDTH bits,
// with valid/ready handshakes on operands and result.
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    serial_fa_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort takes priority, including on the final bit.
                    if (abort) begin
                        state    <= IDLE;
                        sum      <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        sum   <= {fa_s, sum[WIDTH-1:1]};
                        carry <= fa_co;
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= DONE;
                            cout      <= fa_co;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases with literal results plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted pair yields a+b+cin exactly W cycles later,
    // unless aborted while in flight; the result is held until the consumer takes it.
    logic [W:0] m_res;
    bit         m_valid;
    bit         m_flight;
    bit         m_zero;
    int         m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  = 0;
            m_flight = 0;
            m_zero   = 1;
            m_rem    = 0;
            m_res    = '0;
        end else if (m_flight) begin
            if (abort) begin
                m_flight = 0;
                m_zero   = 1;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_flight = 0;
                    m_valid  = 1;
                end
            end
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (in_valid) begin
            m_flight = 1;
            m_rem    = W;
            m_res    = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            m_zero   = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!(m_flight || m_valid)));
            check("busy", 32'(busy), 32'(m_flight || m_valid));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid || m_zero)
                check("result", 32'({cout, sum}), m_valid ? 32'(m_res) : 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        cin      = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [W:0] got;
        int         cnt;
        int         n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'({cout, sum}), 32'd0);

        // 0 + 0: busy for exactly W+1 cycles with out_ready high
        send(8'h00, 8'h00, 1'b0);
        check("model_pin_00", 32'(m_res), 32'h000);
        got = '1;
        cnt = 0;
        n   = 0;
        while (busy && n < 50) begin
            cnt++;
            if (out_valid) got = {cout, sum};
            @(negedge clk);
            n++;
        end
        check("busy_cycles", 32'(cnt), 32'd9);
        check("res_00", 32'(got), 32'h000);

        // FF + 01 with consumer stalled, then 3C + 42
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 1'b0);
        check("model_pin_ff01", 32'(m_res), 32'h100);
        repeat (12) begin
            check("in_ready_held_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        check("ff01_valid", 32'(out_valid), 32'd1);
        check("res_ff01", 32'({cout, sum}), 32'h100);
        out_ready = 1'b1;
        @(negedge clk);
        send(8'h3C, 8'h42, 1'b0);
        wait_valid();
        check("res_3c42", 32'({cout, sum}), 32'h07E);
        @(negedge clk);

        // A5 + 5A + 1 held in DONE; in_valid pulses must be ignored
        out_ready = 1'b0;
        send(8'hA5, 8'h5A, 1'b1);
        wait_valid();
        check("res_a55a", 32'({cout, sum}), 32'h100);
        repeat (5) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'({cout, sum}), 32'h100);
        end
        in_valid  = 1'b0;
        check("done_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("after_hs_valid", 32'(out_valid), 32'd0);
        check("after_hs_ready", 32'(in_ready), 32'd1);

        // Abort in RUN cycle 3, then 10 + 20
        send(8'h7F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'({cout, sum}), 32'd0);
        repeat (10) begin
            check("abort_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send(8'h10, 8'h20, 1'b0);
        wait_valid();
        check("res_1020", 32'({cout, sum}), 32'h030);
        @(negedge clk);

        // Asynchronous reset mid-RUN, then 80 + 80
        send(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_result", 32'({cout, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h80, 8'h80, 1'b0);
        check("model_pin_8080", 32'(m_res), 32'h100);
        wait_valid();
        check("res_8080", 32'({cout, sum}), 32'h100);
        @(negedge clk);

        // Abort coinciding with the final RUN edge
        send(8'h55, 8'hAA, 1'b0);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("last_abort_valid", 32'(out_valid), 32'd0);
        check("last_abort_busy", 32'(busy), 32'd0);
        repeat (3) begin
            check("last_abort_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            abort     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
